multicycle_sequencer: RTL and testbench
=======================================

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter MAX_WAIT, default 15: the maximum number of MEM cycles with mem_ready low before the sequencer faults.
REQ-002 clock  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 instruction  input  32  ROM output for the current PC.
REQ-005 status  input  4  ALU flags {V,C,N,Z} = status[3:0], valid during EXEC.
REQ-006 mem_ready  input  1  RAM access-complete handshake.
REQ-007 state  output  3  current FSM state encoding.
REQ-008 ir_load, reg_read, alu_en, reg_write  output  1 each  per-phase datapath enables.
REQ-009 mem_req, mem_we  output  1 each  RAM request and write qualifier.
REQ-010 pc_inc, pc_branch  output  1 each  PC update pulses.
REQ-011 halted, fault  output  1 each  sticky terminal indicators.
REQ-012 retired_count  output  32  retired-instruction count; present only under SEQ_RETIRE_COUNT_EN.

Function
REQ-013 States SHALL use this encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
REQ-014 Outputs SHALL be Moore-decoded from state and the internal IR, as follows:
- ir_load in FETCH only.
- reg_read in DECODE only.
- alu_en in EXEC only.
- mem_req in MEM only.
- mem_we in MEM for STUR only.
- reg_write in WB only.
- halted in HALT only.
- fault in FAULT only.
REQ-015 The 32-bit internal IR SHALL capture instruction on the rising edge that ends FETCH; decoding SHALL use the IR only.
REQ-016 Instruction classes are decoded from the IR:
- LDUR: [31:21]=11111000010.
- STUR: [31:21]=11111000000.
- B: [31:26]=000101.
- CBZ: [31:24]=10110100.
- CBNZ: [31:24]=10110101.
- BCOND: [31:24]=01010100.
- HALT: IR=32'hFFFF_FFFF.
- ALU: every other encoding.
REQ-017 Transitions SHALL be:
- IDLE->FETCH, FETCH->DECODE, DECODE->EXEC.
- EXEC->WB for ALU; EXEC->MEM for LDUR and STUR; EXEC->FETCH for branches.
- MEM->WB for LDUR and MEM->FETCH for STUR, each on the cycle after mem_ready is sampled high.
- WB->FETCH.
- DECODE->HALT for a HALT instruction.
REQ-018 Exactly one of pc_inc/pc_branch SHALL pulse for one cycle on the last cycle of each retired instruction:
- ALU and LDUR: in WB.
- STUR: in the MEM cycle where mem_ready=1.
- Branches: in EXEC.
REQ-019 Branches SHALL be resolved as follows; an untaken branch pulses pc_inc:
- B: always taken.
- CBZ: taken if Z=1.
- CBNZ: taken if Z=0.
- BCOND with IR[3:0]: EQ(0) taken if Z, NE(1) taken if !Z, GE(A) taken if N==V, LT(B) taken if N!=V.
- BCOND with any other IR[3:0]: not taken.
REQ-020 mem_req and mem_we SHALL remain stable from MEM entry until the cycle mem_ready=1 is sampled; mem_ready outside MEM SHALL be ignored.
REQ-021 The wait counter SHALL clear on MEM entry and increment on each MEM cycle with mem_ready=0.
REQ-022 When the wait counter reaches MAX_WAIT, the FSM SHALL enter FAULT with no reg_write and no PC pulse.
REQ-023 If mem_ready=1 arrives in the same cycle the counter reaches MAX_WAIT, completion SHALL take priority over fault.
REQ-024 HALT and FAULT SHALL be absorbing until reset.

Reset
REQ-025 Asserting reset SHALL immediately force state=IDLE, IR=0, wait counter=0, retired_count=0, and every output to 0, including mid-MEM with mem_req high.
REQ-026 The first FETCH SHALL occur on the second rising edge after reset deasserts.

Configuration
REQ-027 With SEQ_RETIRE_COUNT_EN defined, retired_count SHALL increment by 1 on every pc_inc or pc_branch pulse, wrap from 32'hFFFF_FFFF to 0, and not count HALT.
REQ-028 Without SEQ_RETIRE_COUNT_EN, the port, counter and logic SHALL be absent.

Structure
REQ-029 A shared package SHALL hold the state enum, the instruction-class enum, the opcode constants and the condition-code constants.
REQ-030 A single sub-module, seq_branch_eval, SHALL implement the combinational class/condition/status-to-taken logic; the FSM SHALL remain in multicycle_sequencer.

Verification
REQ-031 ALU op 8B020020 with mem_ready tied 0 -> states 1,2,3,5,1; reg_write in WB; pc_inc in WB; retired_count=1.
REQ-032 LDUR F8400041 with mem_ready high on the 3rd MEM cycle -> mem_req held for 3 cycles, mem_we=0, then WB with reg_write and pc_inc.
REQ-033 STUR F8000041 with mem_ready low for MAX_WAIT=15 cycles -> FAULT (state=7, fault=1), no pc pulse, sticky for 20 further cycles.
REQ-034 Branch cases:
- CBZ B4000040 with Z=1 -> pc_branch in EXEC.
- BCOND 5400000B with N=1, V=0 -> pc_branch.
- BCOND 54000001 with Z=1 -> pc_inc.
REQ-035 Reset asserted mid-MEM (mem_req=1), asynchronously between edges -> all outputs 0 before the next edge, then IDLE->FETCH.
REQ-036 Instruction FFFFFFFF -> halted=1 after DECODE; retired_count unchanged; mem_ready pulses ignored.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and constants for the multicycle sequencer.
// Contents: FSM state encoding, instruction-class enum, opcode field
// constants, BCOND condition codes and the IR class decoder.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        IC_ALU,
        IC_LDUR,
        IC_STUR,
        IC_B,
        IC_CBZ,
        IC_CBNZ,
        IC_BCOND,
        IC_HALT
    } iclass_t;

    localparam logic [10:0] OP_LDUR   = 11'b11111000010;
    localparam logic [10:0] OP_STUR   = 11'b11111000000;
    localparam logic [5:0]  OP_B      = 6'b000101;
    localparam logic [7:0]  OP_CBZ    = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ   = 8'b10110101;
    localparam logic [7:0]  OP_BCOND  = 8'b01010100;
    localparam logic [31:0] INSN_HALT = 32'hFFFF_FFFF;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;

    // HALT is checked first: its all-ones pattern must not fall into
    // any other class.
    function automatic iclass_t decode_class(input logic [31:0] ir);
        iclass_t c;
        if (ir == INSN_HALT)            c = IC_HALT;
        else if (ir[31:21] == OP_LDUR)  c = IC_LDUR;
        else if (ir[31:21] == OP_STUR)  c = IC_STUR;
        else if (ir[31:26] == OP_B)     c = IC_B;
        else if (ir[31:24] == OP_CBZ)   c = IC_CBZ;
        else if (ir[31:24] == OP_CBNZ)  c = IC_CBNZ;
        else if (ir[31:24] == OP_BCOND) c = IC_BCOND;
        else                            c = IC_ALU;
        return c;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_branch_eval.sv
// seq_branch_eval: combinational branch resolution.
// Ports:
//   iclass    - decoded instruction class of the IR
//   cond      - BCOND condition field (IR[3:0])
//   status    - ALU flags {V,C,N,Z}
//   is_branch - class is B/CBZ/CBNZ/BCOND
//   taken     - branch is taken under the current flags
module seq_branch_eval
    import multicycle_sequencer_pkg::*;
(
    input  iclass_t    iclass,
    input  logic [3:0] cond,
    input  logic [3:0] status,
    output logic       is_branch,
    output logic       taken
);

    logic flag_z, flag_n, flag_v;
    logic unused_carry;

    assign flag_z       = status[0];
    assign flag_n       = status[1];
    assign flag_v       = status[3];
    assign unused_carry = status[2];

    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        case (iclass)
            IC_B: begin
                is_branch = 1'b1;
                taken     = 1'b1;
            end
            IC_CBZ: begin
                is_branch = 1'b1;
                taken     = flag_z;
            end
            IC_CBNZ: begin
                is_branch = 1'b1;
                taken     = !flag_z;
            end
            IC_BCOND: begin
                is_branch = 1'b1;
                case (cond)
                    CC_EQ:   taken = flag_z;
                    CC_NE:   taken = !flag_z;
                    CC_GE:   taken = (flag_n == flag_v);
                    CC_LT:   taken = (flag_n != flag_v);
                    default: taken = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multicycle instruction sequencer FSM.
// Optional feature macro: SEQ_RETIRE_COUNT_EN adds the retired_count port.
// Ports:
//   clock, reset       - system clock, async active-high reset
//   instruction        - ROM word for the current PC, latched at end of FETCH
//   status             - ALU flags {V,C,N,Z}, used in EXEC
//   mem_ready          - RAM completion, only looked at in MEM
//   state              - current FSM state
//   ir_load .. mem_we  - per-phase datapath enables (registered)
//   pc_inc, pc_branch  - one-cycle PC update pulse on the retiring cycle
//   halted, fault      - sticky terminal indicators
//   retired_count      - retired instruction count (optional)
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [3:0]  status,
    input  logic        mem_ready,
    output logic [2:0]  state,
    output logic        ir_load,
    output logic        reg_read,
    output logic        alu_en,
    output logic        reg_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        pc_inc,
    output logic        pc_branch,
    output logic        halted,
    output logic        fault
`ifdef SEQ_RETIRE_COUNT_EN
    ,
    output logic [31:0] retired_count
`endif
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    state_t        state_q, state_nxt;
    logic [31:0]   ir;
    logic [WW-1:0] wait_cnt;
    iclass_t       iclass;
    logic          is_branch, taken;

    assign iclass = decode_class(ir);
    assign state  = state_q;

    seq_branch_eval u_branch_eval (
        .iclass    (iclass),
        .cond      (ir[3:0]),
        .status    (status),
        .is_branch (is_branch),
        .taken     (taken)
    );

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:   state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (iclass == IC_HALT) state_nxt = ST_HALT;
                else                   state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (iclass == IC_ALU)                             state_nxt = ST_WB;
                else if (iclass == IC_LDUR || iclass == IC_STUR)  state_nxt = ST_MEM;
                else                                              state_nxt = ST_FETCH;
            end
            ST_MEM: begin
                // completion wins over timeout on the same cycle
                if (mem_ready) begin
                    if (iclass == IC_STUR) state_nxt = ST_FETCH;
                    else                   state_nxt = ST_WB;
                end else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_WB:     state_nxt = ST_FETCH;
            ST_HALT:   state_nxt = ST_HALT;
            ST_FAULT:  state_nxt = ST_FAULT;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Enables are registered from the next state, so each one is a clean
    // Moore decode of the state it belongs to.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ir        <= '0;
            wait_cnt  <= '0;
            ir_load   <= 1'b0;
            reg_read  <= 1'b0;
            alu_en    <= 1'b0;
            reg_write <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            halted    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (state_q == ST_FETCH) ir <= instruction;
            // held at zero outside MEM, which gives the clear on MEM entry
            if (state_q != ST_MEM)  wait_cnt <= '0;
            else if (!mem_ready)    wait_cnt <= wait_cnt + 1'b1;
            ir_load   <= (state_nxt == ST_FETCH);
            reg_read  <= (state_nxt == ST_DECODE);
            alu_en    <= (state_nxt == ST_EXEC);
            reg_write <= (state_nxt == ST_WB);
            mem_req   <= (state_nxt == ST_MEM);
            mem_we    <= (state_nxt == ST_MEM) && (iclass == IC_STUR);
            halted    <= (state_nxt == ST_HALT);
            fault     <= (state_nxt == ST_FAULT);
        end
    end

    // PC pulses depend on flags and mem_ready within the retiring cycle.
    assign pc_branch = (state_q == ST_EXEC) && is_branch && taken;
    assign pc_inc    = ((state_q == ST_EXEC) && is_branch && !taken)
                     || (state_q == ST_WB)
                     || ((state_q == ST_MEM) && (iclass == IC_STUR) && mem_ready);

`ifdef SEQ_RETIRE_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                    retired_count <= '0;
        else if (pc_inc || pc_branch) retired_count <= retired_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: the stimulus process queues the
// expected retire/terminal events, the monitor pops them whenever the DUT
// presents a PC pulse or a rising halted/fault.
module tb_multicycle_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = '0;
    logic [3:0]  status = '0;
    logic        mem_ready = 1'b0;
    logic [2:0]  state;
    logic        ir_load, reg_read, alu_en, reg_write, mem_req, mem_we;
    logic        pc_inc, pc_branch, halted, fault;
`ifdef SEQ_RETIRE_COUNT_EN
    logic [31:0] retired_count;
`endif

    multicycle_sequencer #(.MAX_WAIT(15)) dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .status      (status),
        .mem_ready   (mem_ready),
        .state       (state),
        .ir_load     (ir_load),
        .reg_read    (reg_read),
        .alu_en      (alu_en),
        .reg_write   (reg_write),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .pc_inc      (pc_inc),
        .pc_branch   (pc_branch),
        .halted      (halted),
        .fault       (fault)
`ifdef SEQ_RETIRE_COUNT_EN
        ,
        .retired_count (retired_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] st;
        logic       inc;
        logic       br;
        logic       rw;
        logic       we;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] insn_v = '0;
    logic [3:0]  status_v = '0;
    logic        fault_d = 1'b0;
    logic        halted_d = 1'b0;

    function automatic ev_t mk_ev(input logic [2:0] st, input logic inc,
                                  input logic br, input logic rw, input logic we);
        ev_t e;
        e.st = st; e.inc = inc; e.br = br; e.rw = rw; e.we = we;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock cycle: inputs change just after the rising edge, the
    // caller samples at the falling edge.
    task automatic cyc(input logic mr);
        @(posedge clock);
        #1;
        mem_ready   = mr;
        instruction = insn_v;
        status      = status_v;
        @(negedge clock);
    endtask

    // Asserts reset between edges, checks that every output is already
    // zero before the next edge, then releases and checks IDLE.
    task automatic do_reset();
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("reset_outputs_zero",
              {19'd0, state, ir_load, reg_read, alu_en, reg_write, mem_req,
               mem_we, pc_inc, pc_branch, halted, fault}, 32'd0);
`ifdef SEQ_RETIRE_COUNT_EN
        check("reset_retired_count", retired_count, 32'd0);
`endif
        @(posedge clock);
        #2 reset = 1'b0;
        mem_ready = 1'b0;
        @(negedge clock);
        check("reset_idle", {29'd0, state}, 32'd0);
    endtask

    // Monitor / scoreboard.
    always @(negedge clock) begin
        ev_t act, exp_e;
        if (reset) begin
            fault_d  = 1'b0;
            halted_d = 1'b0;
        end else begin
            if (pc_inc || pc_branch || (fault && !fault_d) || (halted && !halted_d)) begin
                act = mk_ev(state, pc_inc, pc_branch, reg_write, mem_we);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event {st,inc,br,rw,we} actual=%b required=none", act);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (act !== exp_e) begin
                        errors++;
                        $display("FAIL event {st,inc,br,rw,we} actual=%b required=%b", act, exp_e);
                    end
                end
            end
            fault_d  = fault;
            halted_d = halted;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] insn;
        logic [3:0]  flags;
        logic        tk;
    } br_vec_t;

    br_vec_t br_tab[10];
    logic [2:0] exp_st;

    initial begin
        br_tab[0] = '{32'hB400_0040, 4'b0001, 1'b1}; // CBZ, Z=1
        br_tab[1] = '{32'h5400_000B, 4'b0010, 1'b1}; // B.LT, N=1 V=0
        br_tab[2] = '{32'h5400_0001, 4'b0001, 1'b0}; // B.NE, Z=1
        br_tab[3] = '{32'hB400_0040, 4'b0000, 1'b0}; // CBZ, Z=0
        br_tab[4] = '{32'hB500_0000, 4'b0000, 1'b1}; // CBNZ, Z=0
        br_tab[5] = '{32'h1400_0000, 4'b0000, 1'b1}; // B
        br_tab[6] = '{32'h5400_000A, 4'b1010, 1'b1}; // B.GE, N=V=1
        br_tab[7] = '{32'h5400_000A, 4'b1000, 1'b0}; // B.GE, N=0 V=1
        br_tab[8] = '{32'h5400_0002, 4'b1111, 1'b0}; // unsupported cond
        br_tab[9] = '{32'h5400_0000, 4'b0001, 1'b1}; // B.EQ, Z=1

        // ALU op retires through WB, then HALT is absorbing.
        do_reset();
        insn_v = 32'h8B02_0020; status_v = 4'b0000;
        exp_q.push_back(mk_ev(3'd5, 1'b1, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk_ev(3'd6, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 1; i <= 7; i++) begin
            if (i == 5) insn_v = 32'hFFFF_FFFF;
            cyc(1'b0);
            case (i)
                1, 5:    exp_st = 3'd1;
                2, 6:    exp_st = 3'd2;
                3:       exp_st = 3'd3;
                4:       exp_st = 3'd5;
                default: exp_st = 3'd6;
            endcase
            check($sformatf("alu_halt_state_c%0d", i), {29'd0, state}, {29'd0, exp_st});
        end
`ifdef SEQ_RETIRE_COUNT_EN
        check("alu_retired_count", retired_count, 32'd1);
`endif
        for (int i = 0; i < 10; i++) begin
            cyc(i[0]);
            check("halt_sticky", {28'd0, state, halted}, {28'd0, 3'd6, 1'b1});
        end
`ifdef SEQ_RETIRE_COUNT_EN
        check("halt_retired_count", retired_count, 32'd1);
`endif

        // LDUR: mem_ready pulses outside MEM ignored, ready on 3rd MEM cycle.
        do_reset();
        insn_v = 32'hF840_0041; status_v = 4'b0000;
        exp_q.push_back(mk_ev(3'd5, 1'b1, 1'b0, 1'b1, 1'b0));
        for (int i = 1; i <= 8; i++) begin
            cyc((i <= 3) || (i == 6));
            case (i)
                1, 8:    exp_st = 3'd1;
                2:       exp_st = 3'd2;
                3:       exp_st = 3'd3;
                7:       exp_st = 3'd5;
                default: exp_st = 3'd4;
            endcase
            check($sformatf("ldur_state_c%0d", i), {29'd0, state}, {29'd0, exp_st});
            if (i >= 4 && i <= 6)
                check($sformatf("ldur_memreq_we_c%0d", i), {30'd0, mem_req, mem_we}, 32'd2);
            if (i == 7)
                check("ldur_memreq_dropped", {31'd0, mem_req}, 32'd0);
        end

        // STUR timeout: 15 MEM cycles with mem_ready low -> FAULT, sticky.
        do_reset();
        insn_v = 32'hF800_0041;
        exp_q.push_back(mk_ev(3'd7, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 1; i <= 19; i++) begin
            cyc(1'b0);
            if (i <= 3)       exp_st = i[2:0];
            else if (i <= 18) exp_st = 3'd4;
            else              exp_st = 3'd7;
            check($sformatf("stur_to_state_c%0d", i), {29'd0, state}, {29'd0, exp_st});
            if (i == 4)
                check("stur_memreq_we", {30'd0, mem_req, mem_we}, 32'd3);
        end
        for (int i = 0; i < 20; i++) begin
            cyc(i[1]);
            check("fault_sticky", {27'd0, state, fault, mem_req}, {27'd0, 3'd7, 1'b1, 1'b0});
        end

        // STUR: ready on the 15th MEM cycle completes instead of faulting.
        do_reset();
        insn_v = 32'hF800_0041;
        exp_q.push_back(mk_ev(3'd4, 1'b1, 1'b0, 1'b0, 1'b1));
        for (int i = 1; i <= 18; i++) cyc(i == 18);
        check("stur_edge_in_mem", {29'd0, state}, 32'd4);
        cyc(1'b0);
        check("stur_edge_to_fetch", {29'd0, state}, 32'd1);

        // Reset asserted while MEM holds mem_req high.
        do_reset();
        insn_v = 32'hF800_0041;
        for (int i = 1; i <= 5; i++) cyc(1'b0);
        check("mid_mem_memreq", {29'd0, state, mem_req}, {28'd0, 3'd4, 1'b1});
        do_reset();
        cyc(1'b0);
        check("post_reset_fetch", {29'd0, state}, 32'd1);

        // Branch resolution table.
        foreach (br_tab[k]) begin
            do_reset();
            insn_v = br_tab[k].insn; status_v = br_tab[k].flags;
            exp_q.push_back(mk_ev(3'd3, !br_tab[k].tk, br_tab[k].tk, 1'b0, 1'b0));
            cyc(1'b0); cyc(1'b0); cyc(1'b0);
            check($sformatf("br%0d_exec_state", k), {29'd0, state}, 32'd3);
            cyc(1'b0);
            check($sformatf("br%0d_fetch_state", k), {29'd0, state}, 32'd1);
        end

        @(posedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
